// File: rtl/rom_read_arbiter_pkg.sv
// rom_read_arbiter_pkg: shared state encoding and ROM geometry for the ROM read arbiter
package rom_read_arbiter_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t READ = 2'd1;
  localparam state_t RESP = 2'd2;
  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 8;
endpackage

// File: rtl/rom_read_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, first request after last grant wins
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  // scan farthest offset first so the nearest requester after last overrides
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last) + k) % N);
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin shared access to a combinational lookup ROM, one access in flight
module rom_read_arbiter
  import rom_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_data
);
  state_t state;
  logic [IW-1:0] grant, last_grant, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
  end
  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );
  assign req_ready = (state == IDLE) ? pick_gnt : '0;
  assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << grant : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      rom_address <= '0;
      rsp_data    <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant       <= pick_idx;
          rom_address <= addr_a[pick_idx];
          state       <= READ;
        end
        READ: begin
          rsp_data <= rom_data;
          state    <= RESP;
        end
        RESP: if (rsp_ready[grant]) begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: scoreboard bench for rom_read_arbiter with an addr*17 ROM model
module tb_rom_read_arbiter;
  logic clk, rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_addr, rsp_data, rom_data;
  logic [3:0] rom_address;
  typedef struct { int idx; logic [7:0] data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;
  int glog[$], acc_cyc[$];
  int checks = 0, failures = 0, cyc = 0, acc_cnt = 0, rsp_cnt = 0, hs_cyc = 0, last_g = 1;
  int g, eg, s, base;
  logic [1:0] prv;
  rom_read_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rom_address(rom_address), .rom_data(rom_data)
  );
  assign rom_data = {rom_address, rom_address};
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_acc(input int target);
    for (int i = 0; i < 50 && acc_cnt < target; i++) tick(1);
    if (acc_cnt < target) chk("accept_timeout", acc_cnt, target);
  endtask
  task automatic wait_rsp(input int target);
    for (int i = 0; i < 80 && rsp_cnt < target; i++) tick(1);
    if (rsp_cnt < target) chk("rsp_timeout", rsp_cnt, target);
  endtask
  task automatic do_reset();
    rst_n = 0;
    req_valid = 0;
    rsp_ready = 0;
    tick(2);
    sb.delete();
    last_g = 1;
    rst_n = 1;
  endtask
  // monitor: predicts grants, pushes expected data on accept, pops on response handshake
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) prv = 0;
    else begin
      chk("req_onehot", {31'd0, $onehot0(req_ready)}, 1);
      if (req_ready != 0) begin
        g = req_ready[1] ? 1 : 0;
        eg = req_valid[(last_g + 1) % 2] ? (last_g + 1) % 2 : last_g;
        chk("rr_grant", g, eg);
        sb.push_back('{g, (g ? {4'd0, req_addr[7:4]} : {4'd0, req_addr[3:0]}) * 8'd17, cyc});
        glog.push_back(g);
        acc_cyc.push_back(cyc);
        acc_cnt++;
      end
      if (rsp_valid != 0 && prv == 0) begin
        if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else chk("latency", cyc - sb[0].cyc, 2);
      end
      if ((rsp_valid & rsp_ready) != 0 && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_idx", rsp_valid, 2'b01 << e.idx);
        chk("rsp_data", rsp_data, e.data);
        last_g = e.idx;
        hs_cyc = cyc;
        rsp_cnt++;
      end
      prv = rsp_valid;
    end
  end
  initial begin
    rst_n = 0;
    req_valid = 0;
    req_addr = 0;
    rsp_ready = 0;
    tick(2);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rom_address", rom_address, 0);
    rst_n = 1;
    tick(1);
    // single read
    req_addr = {4'd3, 4'd10};
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    wait_acc(acc_cnt + 1);
    req_valid = 0;
    wait_rsp(rsp_cnt + 1);
    chk("single_rsp_drop", rsp_valid, 0);
    // simultaneous requests and fairness
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    s = glog.size();
    base = rsp_cnt;
    wait_acc(acc_cnt + 6);
    req_valid = 0;
    wait_rsp(base + 6);
    for (int i = 0; i < 6; i++) chk("fair_order", glog[s + i], i % 2);
    for (int i = 1; i < 6; i++) chk("accept_spacing", acc_cyc[s + i] - acc_cyc[s + i - 1], 3);
    // backpressure on requester 0 while requester 1 waits
    do_reset();
    base = rsp_cnt;
    req_valid = 2'b11;
    wait_acc(acc_cnt + 1);
    req_valid = 2'b10;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_rsp_data", rsp_data, 8'hAA);
      chk("bp_req_ready", req_ready, 0);
      tick(1);
    end
    rsp_ready = 2'b01;
    wait_acc(acc_cnt + 1);
    req_valid = 0;
    chk("bp_accept_gap", acc_cyc[acc_cyc.size() - 1] - hs_cyc, 1);
    tick(1);
    // wrong-port ready while requester 1 holds the response
    for (int i = 0; i < 4; i++) begin
      rsp_ready = i[0] ? 2'b00 : 2'b01;
      tick(1);
      chk("wrong_port_valid", rsp_valid, 2'b10);
      chk("wrong_port_data", rsp_data, 8'h33);
    end
    rsp_ready = 2'b10;
    wait_rsp(base + 2);
    // asynchronous reset in READ
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    wait_acc(acc_cnt + 1);
    req_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rom_address", rom_address, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    sb.delete();
    last_g = 1;
    tick(1);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_quiet", rsp_valid, 0);
      tick(1);
    end
    // recovery read from requester 1
    base = rsp_cnt;
    rsp_ready = 2'b10;
    req_valid = 2'b10;
    wait_acc(acc_cnt + 1);
    req_valid = 0;
    wait_rsp(base + 1);
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
